// File: rtl/mux2_arbiter_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux2_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic OWNER0 = 1'b0;
    localparam logic OWNER1 = 1'b1;

endpackage

// File: rtl/mux2_arbiter_hold_cnt.sv
// Saturating hold counter: load-to-1 on grant entry, count while the owner
// stays, clear when the bus goes idle.
module mux2_arbiter_hold_cnt #(
    parameter int MAX = 4,
    parameter int CW  = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    logic [CW-1:0] cnt;

    assign at_max = (cnt == CW'(MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(1);
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_max) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter for a shared 2:1 mux with bounded hold under contention
// and a registered output stage aligned with the grants.
//
// state | meaning
// IDLE  | no owner; sel and y hold their last values
// OWN0  | requester 0 owns the bus, y follows d0
// OWN1  | requester 1 owns the bus, y follows d1
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic [WIDTH-1:0] y,
    output logic             y_valid
);

    state_t state;
    state_t state_nxt;
    logic   last;
    logic   sel_nxt;
    logic   at_max;
    logic   entry;
    logic   stay;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req0 && req1) state_nxt = (last == OWNER1) ? OWN0 : OWN1;
                else if (req0)    state_nxt = OWN0;
                else if (req1)    state_nxt = OWN1;
                else              state_nxt = IDLE;
            end
            OWN0: begin
                if (!req0)                 state_nxt = req1 ? OWN1 : IDLE;
                else if (req1 && at_max)   state_nxt = OWN1;
                else                       state_nxt = OWN0;
            end
            OWN1: begin
                if (!req1)                 state_nxt = req0 ? OWN0 : IDLE;
                else if (req0 && at_max)   state_nxt = OWN0;
                else                       state_nxt = OWN1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign entry = (state_nxt != IDLE) && (state_nxt != state);
    assign stay  = (state_nxt != IDLE) && (state_nxt == state);

    // sel only moves when someone is granted; it parks on the last owner when idle
    always_comb begin
        sel_nxt = sel;
        if (state_nxt == OWN0)      sel_nxt = OWNER0;
        else if (state_nxt == OWN1) sel_nxt = OWNER1;
    end

    mux2_arbiter_hold_cnt #(
        .MAX (MAX_HOLD),
        .CW  ($clog2(MAX_HOLD + 1))
    ) u_hold_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (entry),
        .inc    (stay),
        .clr    (state_nxt == IDLE),
        .at_max (at_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            last    <= OWNER1;
            sel     <= OWNER0;
            y       <= '0;
            y_valid <= 1'b0;
        end else begin
            state   <= state_nxt;
            gnt0    <= (state_nxt == OWN0);
            gnt1    <= (state_nxt == OWN1);
            sel     <= sel_nxt;
            y_valid <= (state_nxt != IDLE);
            if (entry) last <= sel_nxt;
            if (state_nxt != IDLE) y <= sel_nxt ? d1 : d0;
        end
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Randomised and directed checks of mux2_arbiter against an ownership model.
module tb_mux2_arbiter;

    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0 = 1'b0;
    logic             req1 = 1'b0;
    logic [WIDTH-1:0] d0 = '0;
    logic [WIDTH-1:0] d1 = '0;
    logic             gnt0, gnt1, sel, y_valid;
    logic [WIDTH-1:0] y;

    int n_checks = 0;
    int n_fail   = 0;

    // model: owner -1 = none, else 0/1; run = consecutive cycles held
    int               m_owner;
    int               m_last;
    int               m_run;
    logic             m_sel;
    logic [WIDTH-1:0] m_y;

    mux2_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .y(y), .y_valid(y_valid)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_run = 0; m_sel = 1'b0; m_y = '0;
    endtask

    task automatic model_step(input logic r0, input logic r1,
                              input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1);
        int  nxt;
        logic mine, other;
        if (m_owner < 0) begin
            if (r0 && r1)  nxt = (m_last == 1) ? 0 : 1;
            else if (r0)   nxt = 0;
            else if (r1)   nxt = 1;
            else           nxt = -1;
        end else begin
            mine  = (m_owner == 1) ? r1 : r0;
            other = (m_owner == 1) ? r0 : r1;
            if (!mine)                          nxt = other ? 1 - m_owner : -1;
            else if (other && m_run >= MAX_HOLD) nxt = 1 - m_owner;
            else                                nxt = m_owner;
        end
        if (nxt >= 0 && nxt != m_owner) begin
            m_run = 1; m_last = nxt;
        end else if (nxt >= 0) begin
            m_run++;
        end
        m_owner = nxt;
        if (nxt >= 0) begin
            m_sel = (nxt == 1);
            m_y   = (nxt == 1) ? a1 : a0;
        end
    endtask

    // apply inputs, take one edge, advance the model, settle past the edge
    task automatic edge_step(input logic r0, input logic r1,
                             input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] a1);
        req0 = r0; req1 = r1; d0 = a0; d1 = a1;
        @(posedge clk);
        model_step(r0, r1, a0, a1);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({gnt0, gnt1, sel, y_valid, y} !== {1'b0, 1'b0, 1'b0, 1'b0, {WIDTH{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_async: got g0=%b g1=%b sel=%b v=%b y=%h, want all zero",
                     gnt0, gnt1, sel, y_valid, y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        edge_step(1'b1, 1'b1, 8'h11, 8'h22);
        n_checks++;
        if ({gnt0, gnt1, y_valid, y} !== {1'b1, 1'b0, 1'b1, 8'h11}) begin
            n_fail++;
            $display("FAIL reset_first_tie: got g0=%b g1=%b v=%b y=%h, want g0=1 g1=0 v=1 y=11",
                     gnt0, gnt1, y_valid, y);
        end
        // reset again mid-ownership: must forget the owner
        edge_step(1'b1, 1'b1, 8'h33, 8'h44);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({gnt0, gnt1, y_valid, y} !== {1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL reset_midop: got g0=%b g1=%b v=%b y=%h, want zeros", gnt0, gnt1, y_valid, y);
        end
        @(negedge clk);
        rst_n = 1'b1;
        edge_step(1'b1, 1'b1, 8'h55, 8'h66);
        n_checks++;
        if ({gnt0, gnt1, y} !== {1'b1, 1'b0, 8'h55}) begin
            n_fail++;
            $display("FAIL reset_midop_tie: got g0=%b g1=%b y=%h, want g0=1 g1=0 y=55", gnt0, gnt1, y);
        end
        edge_step(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_single();
        edge_step(1'b1, 1'b0, 8'hA5, 8'h3C);
        n_checks++;
        if ({gnt0, gnt1, sel, y_valid, y} !== {1'b1, 1'b0, 1'b0, 1'b1, 8'hA5}) begin
            n_fail++;
            $display("FAIL single_grant: got g0=%b g1=%b sel=%b v=%b y=%h, want 1 0 0 1 a5",
                     gnt0, gnt1, sel, y_valid, y);
        end
        edge_step(1'b0, 1'b0, 8'h5A, 8'hC3);
        n_checks++;
        if ({gnt0, gnt1, sel, y_valid, y} !== {1'b0, 1'b0, 1'b0, 1'b0, 8'hA5}) begin
            n_fail++;
            $display("FAIL single_release: got g0=%b g1=%b sel=%b v=%b y=%h, want 0 0 0 0 a5",
                     gnt0, gnt1, sel, y_valid, y);
        end
    endtask

    task automatic test_contention();
        int run_len = 0;
        int prev = -1;
        int cur;
        for (int i = 0; i < 25; i++) begin
            edge_step(1'b1, 1'b1, WIDTH'($urandom), WIDTH'($urandom));
            n_checks++;
            if ({gnt0, gnt1, sel, y_valid, y} !== {m_owner == 0, m_owner == 1, m_sel, m_owner >= 0, m_y}) begin
                n_fail++;
                $display("FAIL contention cyc %0d: got g0=%b g1=%b sel=%b y=%h, want g0=%b g1=%b sel=%b y=%h",
                         i, gnt0, gnt1, sel, y, m_owner == 0, m_owner == 1, m_sel, m_y);
            end
            cur = gnt1 ? 1 : 0;
            if (prev >= 0 && cur != prev) begin
                n_checks++;
                if (run_len != MAX_HOLD) begin
                    n_fail++;
                    $display("FAIL contention_burst: got run %0d, want %0d", run_len, MAX_HOLD);
                end
                run_len = 0;
            end
            run_len++;
            prev = cur;
        end
        edge_step(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_uncontested();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < 20; i++) begin
            v = WIDTH'($urandom);
            edge_step(1'b0, 1'b1, ~v, v);
            n_checks++;
            if ({gnt0, gnt1, y_valid, y} !== {1'b0, 1'b1, 1'b1, v}) begin
                n_fail++;
                $display("FAIL uncontested cyc %0d: got g0=%b g1=%b v=%b y=%h, want 0 1 1 %h",
                         i, gnt0, gnt1, y_valid, y, v);
            end
        end
        edge_step(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_handover();
        logic [WIDTH-1:0] v;
        v = WIDTH'($urandom);
        edge_step(1'b1, 1'b0, 8'h10, 8'h20);
        edge_step(1'b1, 1'b1, 8'h11, 8'h21);
        edge_step(1'b0, 1'b1, 8'h12, v);
        n_checks++;
        if ({gnt0, gnt1, sel, y_valid, y} !== {1'b0, 1'b1, 1'b1, 1'b1, v}) begin
            n_fail++;
            $display("FAIL handover: got g0=%b g1=%b sel=%b v=%b y=%h, want 0 1 1 1 %h",
                     gnt0, gnt1, sel, y_valid, y, v);
        end
    endtask

    task automatic test_tie();
        edge_step(1'b0, 1'b0, 8'h00, 8'h00);
        edge_step(1'b1, 1'b1, 8'h71, 8'h72);
        n_checks++;
        if ({gnt0, gnt1, y} !== {1'b1, 1'b0, 8'h71}) begin
            n_fail++;
            $display("FAIL tie_after_1: got g0=%b g1=%b y=%h, want 1 0 71", gnt0, gnt1, y);
        end
        edge_step(1'b0, 1'b0, 8'h00, 8'h00);
        edge_step(1'b1, 1'b1, 8'h81, 8'h82);
        n_checks++;
        if ({gnt0, gnt1, y} !== {1'b0, 1'b1, 8'h82}) begin
            n_fail++;
            $display("FAIL tie_after_0: got g0=%b g1=%b y=%h, want 0 1 82", gnt0, gnt1, y);
        end
        edge_step(1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_random();
        logic r0, r1;
        for (int i = 0; i < 400; i++) begin
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) != 0);
            edge_step(r0, r1, WIDTH'($urandom), WIDTH'($urandom));
            n_checks++;
            if ({gnt0, gnt1, sel, y_valid, y} !== {m_owner == 0, m_owner == 1, m_sel, m_owner >= 0, m_y}) begin
                n_fail++;
                $display("FAIL random cyc %0d: got g0=%b g1=%b sel=%b v=%b y=%h, want g0=%b g1=%b sel=%b v=%b y=%h",
                         i, gnt0, gnt1, sel, y_valid, y,
                         m_owner == 0, m_owner == 1, m_sel, m_owner >= 0, m_y);
            end
            if (gnt0 && gnt1) begin
                n_fail++;
                $display("FAIL random_exclusive cyc %0d: got both grants high, want at most one", i);
            end
        end
    endtask

    initial begin
        model_reset();
        #12 rst_n = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_uncontested();
        test_handover();
        test_tie();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
